sram_clear_controller: RTL and testbench
========================================

SRAM_CLEAR_CONTROLLER -- requirements
Module: sram_clear_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each SRAM word.
REQ-002 SHALL have parameter SIZE, default 1024, number of SRAM words.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(SIZE), address width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush_req  in  1  request to zero the entire SRAM.
REQ-007 SHALL have ports client_read_en, client_read_addr, client_write_en, client_write_addr, client_write_data  in  1/ADDR_WIDTH/1/ADDR_WIDTH/DATA_WIDTH  client access request.
REQ-008 SHALL have port client_ready  out  1  client access accepted this cycle.
REQ-009 SHALL have ports client_read_data  out  DATA_WIDTH  and client_read_valid  out  1  read return.
REQ-010 SHALL have ports sram_read_en, sram_read_addr, sram_write_en, sram_write_addr, sram_write_data  out  1/ADDR_WIDTH/1/ADDR_WIDTH/DATA_WIDTH  SRAM-side port drive.
REQ-011 SHALL have port sram_read_data  in  DATA_WIDTH  SRAM read result, valid one cycle after sram_read_en.
REQ-012 SHALL have ports busy  out  1  (clear in progress) and flush_done  out  1  (one-cycle completion pulse).

Function
REQ-013 SHALL implement a two-state FSM: CLEAR, ACTIVE.
REQ-014 In CLEAR: sram_write_en=1, sram_write_addr=clear_addr, sram_write_data=0, sram_read_en=0, client_ready=0, busy=1.
REQ-015 clear_addr SHALL increment by 1 each CLEAR cycle, from 0 to SIZE-1; a sweep takes exactly SIZE cycles.
REQ-016 On the CLEAR cycle with clear_addr==SIZE-1: next state ACTIVE, clear_addr reset to 0, flush_done=1 for exactly the following cycle (first ACTIVE cycle).
REQ-017 In ACTIVE: client_ready=1, busy=0; client request signals pass combinationally to the sram_* ports.
REQ-018 In ACTIVE, flush_req=1 SHALL enter CLEAR next cycle; the client access in that same cycle is still accepted and issued.
REQ-019 flush_req asserted during CLEAR SHALL be ignored (no restart, no extra sweep).
REQ-020 Client requests in CLEAR SHALL not reach the SRAM; the client holds them until client_ready=1.
REQ-021 client_read_valid SHALL equal the registered value of (client_read_en && client_ready); client_read_data = sram_read_data, even if state changed to CLEAR in between.
REQ-022 Same-address read and write in ACTIVE: client_read_data on the next cycle SHALL be the new write data (controller bypass; sram bypass not relied upon).
REQ-023 Counter SHALL be ADDR_WIDTH bits; SIZE not a power of two SHALL terminate at SIZE-1, never write addresses >= SIZE.

Reset
REQ-024 While reset=0: state=CLEAR, clear_addr=0, flush_done=0, client_read_valid=0, bypass register=0; busy=1, client_ready=0.
REQ-025 After reset deasserts, the first rising edge SHALL write address 0; the whole SRAM is zeroed before client access.
REQ-026 Reset asserted mid-sweep SHALL restart the sweep from address 0 after release.

Structure
REQ-027 The state typedef SHALL stay local to the module; no additions to the shared defines package.
REQ-028 No sub-module; the SRAM (sram_1r1w) is instantiated by the parent and connected via sram_* ports.

Verification (SIZE=16, DATA_WIDTH=32)
REQ-029 Release reset -> sram_write_en high 16 cycles, addresses 0..15, data 0; flush_done pulse on cycle 17; client_ready high from cycle 17.
REQ-030 ACTIVE, write 0xDEADBEEF @5, then read @5 -> client_read_valid=1, data 0xDEADBEEF one cycle later.
REQ-031 Write 0x12345678 @3 then flush_req, after flush_done read @3 -> 0x00000000.
REQ-032 flush_req pulsed at sweep cycle 8 -> sweep still ends after 16 cycles, single flush_done.
REQ-033 Same-cycle write 0xA5A5A5A5 and read @7 -> next-cycle client_read_data=0xA5A5A5A5.
REQ-034 Reset low at sweep cycle 10, released -> sweep restarts at 0, full 16 writes, client_ready=0 throughout.

Source files
------------

// File: rtl/sram_clear_controller.sv
// rtl/sram_clear_controller.sv - zeroes an external SRAM after reset/flush, then passes client accesses through
module sram_clear_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 1024,
    parameter int ADDR_WIDTH = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_req,
    input  logic                  client_read_en,
    input  logic [ADDR_WIDTH-1:0] client_read_addr,
    input  logic                  client_write_en,
    input  logic [ADDR_WIDTH-1:0] client_write_addr,
    input  logic [DATA_WIDTH-1:0] client_write_data,
    output logic                  client_ready,
    output logic [DATA_WIDTH-1:0] client_read_data,
    output logic                  client_read_valid,
    output logic                  sram_read_en,
    output logic [ADDR_WIDTH-1:0] sram_read_addr,
    output logic                  sram_write_en,
    output logic [ADDR_WIDTH-1:0] sram_write_addr,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    input  logic [DATA_WIDTH-1:0] sram_read_data,
    output logic                  busy,
    output logic                  flush_done
);

    typedef enum logic {CLEAR, ACTIVE} state_t;

    // Terminal count is SIZE-1 so a non power-of-two SIZE never touches addresses >= SIZE.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clear_addr;
    logic [ADDR_WIDTH-1:0]   clear_addr_next;
    logic                    sweep_last;
    logic                    bypass_hit;
    logic [DATA_WIDTH-1:0]   bypass_data;
    logic                    collide;

    assign sweep_last = (state == CLEAR) && (clear_addr == LAST_ADDR);
    assign collide    = (state == ACTIVE) && client_read_en && client_write_en &&
                        (client_read_addr == client_write_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CLEAR;
            clear_addr <= '0;
        end else begin
            state      <= state_next;
            clear_addr <= clear_addr_next;
        end
    end

    always_comb begin
        state_next      = state;
        clear_addr_next = clear_addr;
        client_ready    = 1'b0;
        busy            = 1'b0;
        sram_read_en    = 1'b0;
        sram_read_addr  = '0;
        sram_write_en   = 1'b0;
        sram_write_addr = '0;
        sram_write_data = '0;
        case (state)
            CLEAR: begin
                busy            = 1'b1;
                sram_write_en   = 1'b1;
                sram_write_addr = clear_addr;
                if (sweep_last) begin
                    state_next      = ACTIVE;
                    clear_addr_next = '0;
                end else begin
                    clear_addr_next = clear_addr + 1'b1;
                end
            end
            ACTIVE: begin
                client_ready    = 1'b1;
                sram_read_en    = client_read_en;
                sram_read_addr  = client_read_addr;
                sram_write_en   = client_write_en;
                sram_write_addr = client_write_addr;
                sram_write_data = client_write_data;
                if (flush_req) begin
                    state_next = CLEAR;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // Same-address read+write returns the new data without relying on SRAM write-through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_done        <= 1'b0;
            client_read_valid <= 1'b0;
            bypass_hit        <= 1'b0;
            bypass_data       <= '0;
        end else begin
            flush_done        <= sweep_last;
            client_read_valid <= client_read_en && client_ready;
            bypass_hit        <= collide;
            if (collide) begin
                bypass_data <= client_write_data;
            end
        end
    end

    assign client_read_data = bypass_hit ? bypass_data : sram_read_data;

endmodule

// File: tb/tb_sram_clear_controller.sv
// tb/tb_sram_clear_controller.sv - directed bench with read scoreboard for sram_clear_controller
module tb_sram_clear_controller;

    localparam int DW = 32;
    localparam int SZ = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush_req;
    logic          client_read_en;
    logic [AW-1:0] client_read_addr;
    logic          client_write_en;
    logic [AW-1:0] client_write_addr;
    logic [DW-1:0] client_write_data;
    logic          client_ready;
    logic [DW-1:0] client_read_data;
    logic          client_read_valid;
    logic          sram_read_en;
    logic [AW-1:0] sram_read_addr;
    logic          sram_write_en;
    logic [AW-1:0] sram_write_addr;
    logic [DW-1:0] sram_write_data;
    logic [DW-1:0] sram_read_data;
    logic          busy;
    logic          flush_done;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem     [SZ];
    logic [DW-1:0] ref_mem [SZ];
    logic [DW-1:0] exp_q[$];

    sram_clear_controller #(.DATA_WIDTH(DW), .SIZE(SZ), .ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush_req         (flush_req),
        .client_read_en    (client_read_en),
        .client_read_addr  (client_read_addr),
        .client_write_en   (client_write_en),
        .client_write_addr (client_write_addr),
        .client_write_data (client_write_data),
        .client_ready      (client_ready),
        .client_read_data  (client_read_data),
        .client_read_valid (client_read_valid),
        .sram_read_en      (sram_read_en),
        .sram_read_addr    (sram_read_addr),
        .sram_write_en     (sram_write_en),
        .sram_write_addr   (sram_write_addr),
        .sram_write_data   (sram_write_data),
        .sram_read_data    (sram_read_data),
        .busy              (busy),
        .flush_done        (flush_done)
    );

    always #5 clk = ~clk;

    // Read-before-write SRAM: a same-address collision returns the old word.
    always @(posedge clk) begin
        if (sram_read_en) sram_read_data <= mem[sram_read_addr];
        if (sram_write_en) mem[sram_write_addr] <= sram_write_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drop_inputs();
        flush_req         = 1'b0;
        client_read_en    = 1'b0;
        client_read_addr  = '0;
        client_write_en   = 1'b0;
        client_write_addr = '0;
        client_write_data = '0;
    endtask

    // One ACTIVE cycle: drive at a negedge, check the read return at the next negedge.
    task automatic cycle(input logic re, input logic [AW-1:0] ra, input logic we,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic fl);
        client_read_en    = re;
        client_read_addr  = ra;
        client_write_en   = we;
        client_write_addr = wa;
        client_write_data = wd;
        flush_req         = fl;
        #1;
        chk("ready", client_ready, 1);
        chk("pass_we", sram_write_en, we);
        chk("pass_re", sram_read_en, re);
        if (re) exp_q.push_back((we && wa == ra) ? wd : ref_mem[ra]);
        if (we) ref_mem[wa] = wd;
        @(negedge clk);
        drop_inputs();
        if (exp_q.size() > 0) begin
            chk("rvalid", client_read_valid, 1);
            chk("rdata", client_read_data, exp_q.pop_front());
        end else begin
            chk("rvalid_idle", client_read_valid, 0);
        end
        if (fl) begin
            for (int i = 0; i < SZ; i++) ref_mem[i] = '0;
        end
    endtask

    // Called at the negedge where the first CLEAR cycle (address 0) is visible.
    task automatic sweep_check(input int pulse_at);
        for (int i = 0; i < SZ; i++) begin
            client_read_en    = 1'b1;
            client_read_addr  = AW'(SZ - 1 - i);
            client_write_en   = 1'b1;
            client_write_addr = AW'(SZ - 1 - i);
            client_write_data = 32'hFFFF_0000;
            flush_req         = (i == pulse_at);
            #1;
            chk("sweep_we", sram_write_en, 1);
            chk("sweep_addr", sram_write_addr, i);
            chk("sweep_data", sram_write_data, 0);
            chk("sweep_re", sram_read_en, 0);
            chk("sweep_ready", client_ready, 0);
            chk("sweep_busy", busy, 1);
            chk("sweep_done_early", flush_done, 0);
            @(negedge clk);
        end
        drop_inputs();
        chk("done_pulse", flush_done, 1);
        chk("ready_after", client_ready, 1);
        chk("busy_after", busy, 0);
        chk("rvalid_after", client_read_valid, 0);
        @(negedge clk);
        chk("done_single", flush_done, 0);
        chk("still_active", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < SZ; i++) begin
            mem[i]     = 32'hBAD0_0000 | 32'(i);
            ref_mem[i] = '0;
        end
        reset = 1'b0;
        drop_inputs();
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_ready", client_ready, 0);
        chk("rst_done", flush_done, 0);
        chk("rst_rvalid", client_read_valid, 0);
        chk("rst_waddr", sram_write_addr, 0);

        reset = 1'b1;
        sweep_check(-1);
        for (int i = 0; i < SZ; i++) chk("zeroed", mem[i], 0);

        cycle(0, 0, 1, 5, 32'hDEADBEEF, 0);
        cycle(1, 5, 0, 0, 0, 0);

        cycle(0, 0, 1, 3, 32'h12345678, 0);
        cycle(1, 3, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        sweep_check(-1);
        cycle(1, 3, 0, 0, 0, 0);
        cycle(1, 5, 0, 0, 0, 0);

        cycle(1, 7, 1, 7, 32'hA5A5A5A5, 0);
        cycle(1, 7, 0, 0, 0, 0);
        cycle(1, 2, 1, 9, 32'h0BADF00D, 0);
        cycle(1, 9, 0, 0, 0, 0);

        // Flush cycle also carries a write; it must still land before the sweep.
        cycle(1, 9, 1, 4, 32'h44444444, 1);
        sweep_check(8);
        chk("flush_cleared_4", mem[4], 0);

        cycle(0, 0, 1, 6, 32'h66666666, 1);
        repeat (10) @(negedge clk);
        chk("mid_sweep_addr", sram_write_addr, 10);
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 1);
        chk("rst_mid_ready", client_ready, 0);
        chk("rst_mid_addr", sram_write_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        sweep_check(-1);
        cycle(1, 6, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
